// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and defaults for the multiply/divide unit
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic MDU_OP_MULT = 1'b0;
  localparam logic MDU_OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    MDU_IDLE,
    MDU_MUL,
    MDU_DIV,
    MDU_FIX,
    MDU_DONE
  } mdu_state_t;

endpackage

// File: rtl/mdu_negate.sv
// rtl/mdu_negate.sv - combinational conditional two's-complement negate
module mdu_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - iterative signed multiply/divide unit with HI/LO registers
module mult_div_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t state, state_next;

  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      count;
  logic               sign_a, sign_b, op_q, dz_flag;
  logic [WIDTH-1:0]   hi, lo;

  logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic               b_zero;

  mdu_negate #(.W(WIDTH)) u_abs_a (.value(a_in), .neg(a_in[WIDTH-1]), .result(a_abs));
  mdu_negate #(.W(WIDTH)) u_abs_b (.value(b_in), .neg(b_in[WIDTH-1]), .result(b_abs));
  mdu_negate #(.W(2*WIDTH)) u_fix_prod (.value(acc), .neg(sign_a ^ sign_b), .result(prod_fix));
  mdu_negate #(.W(WIDTH)) u_fix_quo (.value(acc[WIDTH-1:0]), .neg(sign_a ^ sign_b), .result(quo_fix));
  mdu_negate #(.W(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .neg(sign_a), .result(rem_fix));

  assign b_zero   = (b_in == '0);
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};
  // Trial subtract of the divisor from the remainder shifted left by one dividend bit
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
  assign div_step  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  always_ff @(posedge clock) begin
    if (!Reset) state <= MDU_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != MDU_IDLE);
    done       = 1'b0;
    div_zero   = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (start) begin
          if (op == MDU_OP_DIV) state_next = b_zero ? MDU_DONE : MDU_DIV;
          else                  state_next = MDU_MUL;
        end
      end
      MDU_MUL, MDU_DIV: begin
        if (count == '0) state_next = MDU_FIX;
      end
      MDU_FIX: state_next = MDU_DONE;
      MDU_DONE: begin
        done       = 1'b1;
        div_zero   = dz_flag;
        state_next = MDU_IDLE;
      end
      default: state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!Reset) begin
      acc     <= '0;
      opnd    <= '0;
      count   <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      op_q    <= MDU_OP_MULT;
      dz_flag <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            sign_a  <= a_in[WIDTH-1];
            sign_b  <= b_in[WIDTH-1];
            op_q    <= op;
            count   <= CW'(WIDTH - 1);
            dz_flag <= (op == MDU_OP_DIV) && b_zero;
            opnd    <= (op == MDU_OP_MULT) ? a_abs : b_abs;
            acc     <= {{WIDTH{1'b0}}, ((op == MDU_OP_MULT) ? b_abs : a_abs)};
          end else begin
            if (hi_wr) hi <= wr_data;
            if (lo_wr) lo <= wr_data;
          end
        end
        MDU_MUL: begin
          acc   <= mul_step;
          count <= count - CW'(1);
        end
        MDU_DIV: begin
          acc   <= div_step;
          count <= count - CW'(1);
        end
        MDU_FIX: begin
          if (op_q == MDU_OP_DIV) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_out = hi;
  assign lo_out = lo;

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
Iterative signed multiply/divide unit with HI/LO registers for the multicycle MIPS core. The main controller sequences it for MULT, DIV, MFHI/MFLO and MTHI/MTLO.
- Main controller pulses start with operands from A/B and waits on done.
- Internal FSM runs 32 shift-add or restoring-divide steps, applies the sign, then writes HI/LO.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-low; resets when sampled 0 on a rising clock edge
start  in  1  begin operation; sampled only in IDLE
op  in  1  0=MULT, 1=DIV (signed)
a_in  in  WIDTH  multiplicand / dividend (rs)
b_in  in  WIDTH  multiplier / divisor (rt)
hi_wr  in  1  MTHI strobe, IDLE only
lo_wr  in  1  MTLO strobe, IDLE only
wr_data  in  WIDTH  data for hi_wr/lo_wr
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, HI/LO valid
div_zero  out  1  pulses with done when DIV had b_in=0
hi_out  out  WIDTH  HI register (product high / remainder)
lo_out  out  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset (Reset=0 at an edge): state=IDLE, HI=LO=0, busy=done=div_zero=0, counter=0. This takes effect mid-operation too; any partial result is discarded.

FSM states: IDLE, MUL, DIV, FIX, DONE.
- **IDLE:**
  - start=1 latches |a_in|, |b_in|, sign_a, sign_b and op; counter is set to WIDTH-1.
  - Next state is MUL or DIV.
  - Exception: DIV with b_in=0 goes straight to DONE with div_zero flag set, and HI/LO stay unchanged.
- **MUL:**
  - Each edge performs one shift-add step on a 2*WIDTH accumulator.
  - Exit to FIX after the step with counter=0 (WIDTH steps total).
- **DIV:**
  - Each edge performs one restoring step: shift remainder/quotient left, trial subtract, keep result if non-negative, and set the quotient bit.
  - Exit to FIX after WIDTH steps.
- **FIX:**
  - MUL: if sign_a^sign_b, negate the 2*WIDTH product. HI=upper half, LO=lower half.
  - DIV: LO=quotient, negated if sign_a^sign_b. HI=remainder, negated if sign_a (remainder carries the dividend's sign).
  - Next state is DONE.
- **DONE:** done=1 (and div_zero if flagged) for exactly one cycle, then IDLE. busy drops in the same cycle the state returns to IDLE.

Latency and interface rules:
- Latency: start sampled at edge k → done high in the cycle following edge k+33; HI/LO are updated at edge k+33.
- Divide by zero: done and div_zero are high in the cycle after edge k.
- All arithmetic is two's complement modulo 2^WIDTH; no overflow flag.
- INT_MIN/−1 gives LO=0x80000000, HI=0.
- Start while busy is ignored; no queueing.
- hi_wr/lo_wr while busy are ignored.
- start and hi_wr/lo_wr together in IDLE: start wins and the write is dropped.
- hi_wr and lo_wr together in IDLE: both written.
- Outputs hi_out/lo_out are registered and hold their values between operations.
- a_in/b_in may change after the start edge; the latched copies are used.

Decomposition:
- Shared package mdu_pkg holds:
  - state encodings MDU_IDLE..MDU_DONE;
  - op codes MDU_OP_MULT=0 and MDU_OP_DIV=1;
  - the WIDTH default.
- The main controller imports the op codes to drive op.
- One natural sub-module, mdu_negate: a combinational conditional two's-complement negate, parameterised by width. It is instantiated for operand absolute values (WIDTH) and for the product/quotient/remainder fix-up (2*WIDTH / WIDTH).

Test Plan:
- **Signed MULT:** MULT a=7, b=0xFFFFFFFD (−3) → done 34 cycles after start edge, HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy high throughout.
- **Signed DIV:** DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1), div_zero=0.
- **Boundary operands:**
  - DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
  - MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- **Divide by zero:** MTHI 0x1234, MTLO 0x5678, then DIV a=5, b=0 → done and div_zero in the next cycle; HI=0x1234 and LO=0x5678 unchanged.
- **Start while busy:** start MULT 3×4, re-pulse start with 9×9 at cycle 10 and assert hi_wr at cycle 12 → ignored; result HI=0, LO=12; exactly one done pulse.
- **Reset mid-operation:** Reset=0 at cycle 15 of a DIV → next cycle busy=0, HI=LO=0, no done. A new MULT 2×3 afterwards gives LO=6.
